// File: rtl/pdpu_dot_sequencer_if.sv
// Port bundle between the dot-product sequencer and its surroundings.
// Covers the command, the chunk stream, the PDPU link and the result stream.
interface pdpu_dot_sequencer_if #(
  parameter int unsigned N         = 4,
  parameter int unsigned n_i       = 8,
  parameter int unsigned n_o       = 16,
  parameter int unsigned LEN_WIDTH = 16
);
  logic                 start_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic [n_o-1:0]       acc_init_i;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [N*n_i-1:0]     in_a_i;
  logic [N*n_i-1:0]     in_b_i;

  logic [N*n_i-1:0]     pdpu_operands_a_o;
  logic [N*n_i-1:0]     pdpu_operands_b_o;
  logic [n_o-1:0]       pdpu_acc_o;
  logic [n_o-1:0]       pdpu_result_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [n_o-1:0]       out_result_o;

  logic                 busy_o;
  logic [LEN_WIDTH-1:0] chunks_done_o;

  // Sequencer side.
  modport slave (
    input  start_i, len_i, acc_init_i,
    input  in_valid_i, in_a_i, in_b_i,
    output in_ready_o,
    output pdpu_operands_a_o, pdpu_operands_b_o, pdpu_acc_o,
    input  pdpu_result_i,
    output out_valid_o, out_result_o,
    input  out_ready_i,
    output busy_o, chunks_done_o
  );

  // Environment side: command source, chunk producer, PDPU and result consumer.
  modport master (
    output start_i, len_i, acc_init_i,
    output in_valid_i, in_a_i, in_b_i,
    input  in_ready_o,
    input  pdpu_operands_a_o, pdpu_operands_b_o, pdpu_acc_o,
    output pdpu_result_i,
    input  out_valid_o, out_result_o,
    output out_ready_i,
    input  busy_o, chunks_done_o
  );
endinterface

// File: rtl/pdpu_dot_sequencer.sv
// Feeds operand chunks one at a time into a pipelined posit dot-product unit,
// loops each result back as the next accumulator and returns the final sum.
module pdpu_dot_sequencer #(
  parameter int unsigned N         = 4,
  parameter int unsigned n_i       = 8,
  parameter int unsigned n_o       = 16,
  parameter int unsigned LATENCY   = 5,
  parameter int unsigned LEN_WIDTH = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  pdpu_dot_sequencer_if.slave  bus
);

  localparam int unsigned CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               r_state;
  logic [n_o-1:0]       r_acc;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [CW-1:0]        r_wait_cnt;
  logic [LEN_WIDTH-1:0] r_chunks_done;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [n_o-1:0]       r_out_result;
  logic [N*n_i-1:0]     r_ops_a;
  logic [N*n_i-1:0]     r_ops_b;
  logic [n_o-1:0]       r_pdpu_acc;
  logic                 r_busy;

  // NOTE: every output comes straight from a flop, so each one is assigned
  // with <= in this single clocked block and nothing downstream sees glitches.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_remaining   <= '0;
      r_wait_cnt    <= '0;
      r_chunks_done <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_ops_a       <= '0;
      r_ops_b       <= '0;
      r_pdpu_acc    <= '0;
      r_busy        <= 1'b0;
    end else begin
      // The PDPU sees posit zero except in the single cycle after a handshake.
      r_ops_a    <= '0;
      r_ops_b    <= '0;
      r_pdpu_acc <= '0;

      unique case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_acc         <= bus.acc_init_i;
            r_chunks_done <= '0;
            r_busy        <= 1'b1;
            if (bus.len_i != '0) begin
              r_remaining <= bus.len_i;
              r_in_ready  <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_remaining  <= '0;
              r_out_valid  <= 1'b1;
              r_out_result <= bus.acc_init_i;
              r_state      <= DONE;
            end
          end
        end

        ISSUE: begin
          if (bus.in_valid_i) begin
            r_ops_a    <= bus.in_a_i;
            r_ops_b    <= bus.in_b_i;
            r_pdpu_acc <= r_acc;
            r_wait_cnt <= LAT;
            r_in_ready <= 1'b0;
            r_state    <= WAIT;
          end
        end

        WAIT: begin
          // Count reaches zero exactly LATENCY cycles after the operands were shown.
          if (r_wait_cnt == '0) begin
            r_acc         <= bus.pdpu_result_i;
            r_remaining   <= r_remaining - LEN_WIDTH'(1);
            r_chunks_done <= r_chunks_done + LEN_WIDTH'(1);
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_out_valid  <= 1'b1;
              r_out_result <= bus.pdpu_result_i;
              r_state      <= DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ISSUE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - CW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o        = r_in_ready;
  assign bus.pdpu_operands_a_o = r_ops_a;
  assign bus.pdpu_operands_b_o = r_ops_b;
  assign bus.pdpu_acc_o        = r_pdpu_acc;
  assign bus.out_valid_o       = r_out_valid;
  assign bus.out_result_o      = r_out_result;
  assign bus.busy_o            = r_busy;
  assign bus.chunks_done_o     = r_chunks_done;

endmodule
